// File: rtl/fixed_mul_arbiter.sv
// Shared signed fixed-point multiplier with round-robin arbitration.
// Requesters compete for one multiplier. One request is granted per cycle.
// Each product passes through two register stages, is shifted right by FRAC,
// is saturated to W bits, and comes back on a strobe tagged with the index of
// the requester that issued it.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   req_valid  per-requester request valid
//   req_a      packed operand A, requester i at [i*W +: W]
//   req_b      packed operand B, same packing
//   req_ready  one-hot grant (combinational from req_valid)
//   res_valid  one-hot result strobe, one cycle per result
//   res_data   shared result bus, qualified by res_valid
//   res_sat    result was clamped, qualified by res_valid
//   busy       a pipeline stage holds a valid entry
module fixed_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int FRAC  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   res_valid,
    output logic [W-1:0]       res_data,
    output logic               res_sat,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       winner;
    logic [N_REQ-1:0]    grant;
    logic                found;
    logic                accept;

    logic                s1_valid;
    logic [PW-1:0]       s1_tag;
    logic signed [W-1:0] s1_a;
    logic signed [W-1:0] s1_b;

    logic                s2_valid;
    logic [PW-1:0]       s2_tag;

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;
    logic                  ovf;
    logic [W-1:0]          sat_val;

    // Search starts one past the last winner, so the last winner is
    // considered last.
    always_comb begin
        int          idx;
        logic [PW-1:0] idx_v;
        grant  = '0;
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(rr_ptr) + k) % N_REQ;
            idx_v = PW'(idx);
            if (!found && req_valid[idx_v]) begin
                found        = 1'b1;
                winner       = idx_v;
                grant[idx_v] = 1'b1;
            end
        end
    end

    assign req_ready = rst_n ? grant : '0;
    assign accept    = found & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= PW'(N_REQ - 1);
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                rr_ptr <= winner;
                s1_tag <= winner;
                s1_a   <= req_a[winner*W +: W];
                s1_b   <= req_b[winner*W +: W];
            end
        end
    end

    // The full-width product, arithmetically shifted, fits in W bits exactly
    // when bits [2W-1:W-1] are all copies of the sign bit.
    assign prod    = s1_a * s1_b;
    assign shifted = prod >>> FRAC;
    assign ovf     = ~(&shifted[2*W-1:W-1]) & (|shifted[2*W-1:W-1]);
    assign sat_val = shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            res_data <= '0;
            res_sat  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag   <= s1_tag;
                res_data <= ovf ? sat_val : shifted[W-1:0];
                res_sat  <= ovf;
            end
        end
    end

    // Gated by rst_n so that an entry already in stage 2 when reset arrives
    // is discarded without a strobe.
    always_comb begin
        res_valid = '0;
        if (s2_valid && rst_n) begin
            res_valid[s2_tag] = 1'b1;
        end
    end

    assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
module tb_fixed_mul_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int FRAC = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   res_valid;
    logic [W-1:0]   res_data;
    logic           res_sat;
    logic           busy;

    fixed_mul_arbiter #(.N_REQ(N), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
        .res_sat(res_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int         tag;
        logic [W-1:0] d;
        logic       s;
        int         c;
    } ent_t;

    ent_t         q[$];
    int           mptr = N - 1;
    logic [W-1:0] ldata = '0;
    logic         lsat = 1'b0;
    logic [N-1:0] last_acc = '0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Fixed-point product from plain integer arithmetic: floor shift, then clamp.
    function automatic void model_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic s);
        longint p, sh, maxv, minv;
        p    = longint'($signed(a)) * longint'($signed(b));
        sh   = p >>> FRAC;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        s = 1'b1;
        if (sh > maxv)      r = W'(maxv);
        else if (sh < minv) r = W'(minv);
        else begin
            r = W'(sh);
            s = 1'b0;
        end
    endfunction

    // Reference: per-cycle expectations from the grant rule and a queue of
    // accepted operations stamped with their accept cycle.
    logic [N-1:0] eg, erv;
    int           win, id;
    bit           popped, ebusy;
    ent_t         ent;
    logic [W-1:0] md;
    logic         ms;

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            eg  = '0;
            win = -1;
            if (rst_n) begin
                for (int k = 1; k <= N; k++) begin
                    id = (mptr + k) % N;
                    if (win < 0 && req_valid[id]) win = id;
                end
            end
            if (win >= 0) eg[win] = 1'b1;
            erv    = '0;
            popped = 1'b0;
            if (q.size() > 0 && q[0].c == cyc - 2) begin
                popped = 1'b1;
                ent = q.pop_front();
                if (rst_n) begin
                    erv[ent.tag] = 1'b1;
                    ldata = ent.d;
                    lsat  = ent.s;
                end
            end
            ebusy = popped || (q.size() > 0);
            cmp("req_ready", 64'(req_ready), 64'(eg));
            cmp("res_valid", 64'(res_valid), 64'(erv));
            if (rst_n) begin
                cmp("res_data", 64'(res_data), 64'(ldata));
                cmp("res_sat", 64'(res_sat), 64'(lsat));
            end
            cmp("busy", 64'(busy), 64'(ebusy));
            last_acc = eg;
            if (!rst_n) begin
                q.delete();
                mptr  = N - 1;
                ldata = '0;
                lsat  = 1'b0;
            end else if (win >= 0) begin
                model_mul(req_a[win*W +: W], req_b[win*W +: W], md, ms);
                ent.tag = win;
                ent.d   = md;
                ent.s   = ms;
                ent.c   = cyc;
                q.push_back(ent);
                mptr = win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        repeat (2) begin
            step();
            rst_n = 1'b0;
            req_valid = '0;
        end
        step();
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic es);
        step();
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        sample();
        cmp("op_ready", 64'(req_ready), 64'(4'b0001 << i));
        step();
        req_valid = '0;
        step();
        sample();
        cmp("op_res_valid", 64'(res_valid), 64'(4'b0001 << i));
        cmp("op_res_data", 64'(res_data), 64'(ed));
        cmp("op_res_sat", 64'(res_sat), 64'(es));
    endtask

    function automatic logic [W-1:0] rand_op();
        int v;
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return W'($urandom());
            default: begin
                v = int'($urandom_range(0, 65535)) - 32768;
                return W'(v);
            end
        endcase
    endfunction

    logic [W-1:0] pr;
    logic         ps;

    initial begin
        // Pin the reference arithmetic with hand-computed values.
        model_mul(32'd4096, 32'd4096, pr, ps);
        cmp("model_1x1", 64'({ps, pr}), 64'({1'b0, 32'd4096}));
        model_mul(32'hFFFF_FFFF, 32'd1, pr, ps);
        cmp("model_floor", 64'({ps, pr}), 64'({1'b0, 32'hFFFF_FFFF}));
        model_mul(32'd6144, 32'hFFFF_E800, pr, ps);
        cmp("model_neg", 64'({ps, pr}), 64'({1'b0, 32'hFFFF_DC00}));
        model_mul(32'h8000_0000, 32'h8000_0000, pr, ps);
        cmp("model_sat", 64'({ps, pr}), 64'({1'b1, 32'h7FFF_FFFF}));

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();
        sample();
        cmp("rst_busy", 64'(busy), 64'(0));
        cmp("rst_res_valid", 64'(res_valid), 64'(0));
        cmp("rst_res_data", 64'(res_data), 64'(0));

        do_op(2, 32'd4096, 32'd4096, 32'd4096, 1'b0);
        do_op(1, 32'hFFFF_F800, 32'd4096, 32'hFFFF_F800, 1'b0);
        do_op(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        do_op(3, 32'd6144, 32'hFFFF_E800, 32'hFFFF_DC00, 1'b0);
        do_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        do_op(1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        do_op(0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);

        // Round robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'((i + 1) * 4096);
            req_b[i*W +: W] = 32'd8192;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            sample();
            if (k < 8) cmp("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 2) cmp("rr_result", 64'(res_valid), 64'(4'b0001 << ((k - 2) % 4)));
        end
        step();
        sample();
        cmp("rr_busy_done", 64'(busy), 64'(0));

        // Rotation with gaps.
        do_reset();
        step(); req_valid = 4'b0010; sample(); cmp("gap_g1", 64'(req_ready), 64'(4'b0010));
        step(); req_valid = 4'b0000; sample(); cmp("gap_idle", 64'(req_ready), 64'(0));
        step(); req_valid = 4'b1001; sample(); cmp("gap_g3", 64'(req_ready), 64'(4'b1000));
        step(); req_valid = 4'b0001; sample(); cmp("gap_g0", 64'(req_ready), 64'(4'b0001));
        step(); req_valid = 4'b0000;

        // Reset while two operations are in flight.
        do_reset();
        step(); req_valid = 4'b0001; sample(); cmp("mid_g0", 64'(req_ready), 64'(4'b0001));
        step(); req_valid = 4'b0010; sample(); cmp("mid_g1", 64'(req_ready), 64'(4'b0010));
        step(); rst_n = 1'b0; req_valid = 4'b0011; sample();
        cmp("mid_rst_ready", 64'(req_ready), 64'(0));
        cmp("mid_rst_res", 64'(res_valid), 64'(0));
        step(); rst_n = 1'b1; sample();
        cmp("mid_after_busy", 64'(busy), 64'(0));
        cmp("mid_after_res", 64'(res_valid), 64'(0));
        cmp("mid_after_g0", 64'(req_ready), 64'(4'b0001));
        step(); req_valid = 4'b0010; sample(); cmp("mid_after_g1", 64'(req_ready), 64'(4'b0010));
        step(); req_valid = 4'b0000;
        repeat (3) step();

        // Random traffic with occasional resets; the reference process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 45) begin
                    req_valid[i] = 1'b1;
                    req_a[i*W +: W] = rand_op();
                    req_b[i*W +: W] = rand_op();
                end
            end
        end
        step();
        rst_n = 1'b1;
        req_valid = '0;
        repeat (4) step();
        sample();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
